// File: rtl/spm_dp_be.sv
// Dual-port scratch pad memory with per-byte write enables, registered reads,
// an optional post-reset clear sweep and deterministic same-address collision handling.
module spm_dp_be #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int BE_W           = DATA_W / 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] if_spm_addr,
  input  logic              if_spm_as_,
  input  logic              if_spm_rw,
  input  logic [BE_W-1:0]   if_spm_be,
  input  logic [DATA_W-1:0] if_spm_wr_data,
  output logic [DATA_W-1:0] if_spm_rd_data,
  output logic              if_spm_rd_vld,
  input  logic [ADDR_W-1:0] mem_spm_addr,
  input  logic              mem_spm_as_,
  input  logic              mem_spm_rw,
  input  logic [BE_W-1:0]   mem_spm_be,
  input  logic [DATA_W-1:0] mem_spm_wr_data,
  output logic [DATA_W-1:0] mem_spm_rd_data,
  output logic              mem_spm_rd_vld,
  output logic              spm_rdy,
  output logic              spm_coll
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic            RW_READ   = 1'b1;
  localparam logic            AS_ENABLE = 1'b0;
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e ST_INIT = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_we_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic acc_a_s, acc_b_s, rd_a_s, rd_b_s, wr_a_s, wr_b_s;

  assign spm_rdy = (state_q == ST_RUN);
  assign acc_a_s = (if_spm_as_  == AS_ENABLE) && spm_rdy;
  assign acc_b_s = (mem_spm_as_ == AS_ENABLE) && spm_rdy;
  assign rd_a_s  = acc_a_s && (if_spm_rw  == RW_READ);
  assign rd_b_s  = acc_b_s && (mem_spm_rw == RW_READ);
  assign wr_a_s  = acc_a_s && (if_spm_rw  != RW_READ);
  assign wr_b_s  = acc_b_s && (mem_spm_rw != RW_READ);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_INIT;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_s = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Port B lanes are written after port A so they win on a same-address merge.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_q[cnt_q] <= {DATA_W{1'b0}};
    end else begin
      if (wr_a_s) begin
        for (int i = 0; i < BE_W; i++) begin
          if (if_spm_be[i]) begin
            mem_q[if_spm_addr][8*i +: 8] <= if_spm_wr_data[8*i +: 8];
          end
        end
      end
      if (wr_b_s) begin
        for (int i = 0; i < BE_W; i++) begin
          if (mem_spm_be[i]) begin
            mem_q[mem_spm_addr][8*i +: 8] <= mem_spm_wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  // Reads sample the pre-write word, giving read-first behaviour on collisions.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      if_spm_rd_data  <= {DATA_W{1'b0}};
      if_spm_rd_vld   <= 1'b0;
      mem_spm_rd_data <= {DATA_W{1'b0}};
      mem_spm_rd_vld  <= 1'b0;
      spm_coll        <= 1'b0;
    end else begin
      if_spm_rd_vld  <= rd_a_s;
      mem_spm_rd_vld <= rd_b_s;
      spm_coll       <= wr_a_s && wr_b_s && (if_spm_addr == mem_spm_addr);
      if (rd_a_s) begin
        if_spm_rd_data <= mem_q[if_spm_addr];
      end
      if (rd_b_s) begin
        mem_spm_rd_data <= mem_q[mem_spm_addr];
      end
    end
  end

endmodule

// File: tb/tb_spm_dp_be.sv
// Self-checking bench for spm_dp_be (ADDR_W=4, CLEAR_ON_RESET=1) with a word-array reference model.
module tb_spm_dp_be;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic          a_as = 1'b1, b_as = 1'b1;
  logic          a_rw = 1'b1, b_rw = 1'b1;
  logic [BW-1:0] a_be = '0, b_be = '0;
  logic [DW-1:0] a_wd = '0, b_wd = '0;
  logic [DW-1:0] a_rd, b_rd;
  logic          a_vld, b_vld, rdy, coll;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] exp_rda = '0, exp_rdb = '0;
  logic          exp_vla = 1'b0, exp_vlb = 1'b0, exp_coll = 1'b0;

  spm_dp_be #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_(reset_),
    .if_spm_addr(a_addr), .if_spm_as_(a_as), .if_spm_rw(a_rw), .if_spm_be(a_be),
    .if_spm_wr_data(a_wd), .if_spm_rd_data(a_rd), .if_spm_rd_vld(a_vld),
    .mem_spm_addr(b_addr), .mem_spm_as_(b_as), .mem_spm_rw(b_rw), .mem_spm_be(b_be),
    .mem_spm_wr_data(b_wd), .mem_spm_rd_data(b_rd), .mem_spm_rd_vld(b_vld),
    .spm_rdy(rdy), .spm_coll(coll)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    a_as = 1'b1;
    b_as = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    exp_rda = '0; exp_rdb = '0; exp_vla = 1'b0; exp_vlb = 1'b0; exp_coll = 1'b0;
  endtask

  // One accepted cycle in RUN: reads see the old word, B's lanes override A's.
  task automatic step();
    exp_vla  = !a_as && a_rw;
    exp_vlb  = !b_as && b_rw;
    if (exp_vla) exp_rda = exp_mem[a_addr];
    if (exp_vlb) exp_rdb = exp_mem[b_addr];
    exp_coll = !a_as && !a_rw && !b_as && !b_rw && (a_addr == b_addr);
    if (!a_as && !a_rw)
      for (int i = 0; i < BW; i++) if (a_be[i]) exp_mem[a_addr][8*i +: 8] = a_wd[8*i +: 8];
    if (!b_as && !b_rw)
      for (int i = 0; i < BW; i++) if (b_be[i]) exp_mem[b_addr][8*i +: 8] = b_wd[8*i +: 8];
    tick();
  endtask

  task automatic test_reset();
    int got;
    // preload nonzero words through port B, then reset and expect a full clear
    for (int i = 0; i < 16; i++) begin
      b_as = 1'b0; b_rw = 1'b0; b_addr = AW'(i); b_be = 4'hF; b_wd = $urandom | 32'h1;
      step();
    end
    idle();
    reset_ = 1'b0;
    #1;
    n_tests++;
    if (a_rd !== 32'h0 || b_rd !== 32'h0 || a_vld !== 1'b0 || b_vld !== 1'b0 || coll !== 1'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a_rd=%h b_rd=%h vld=%b%b coll=%b rdy=%b, expected all zero", a_rd, b_rd, a_vld, b_vld, coll, rdy);
    end
    @(negedge clk);
    reset_ = 1'b1;
    a_as = 1'b0; a_rw = 1'b0; a_addr = 4'd2; a_be = 4'hF; a_wd = 32'hFFFF_FFFF;
    b_as = 1'b0; b_rw = 1'b1; b_addr = 4'd2;
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rdy) begin got = n; break; end
      n_tests++;
      if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_no_vld: got a_vld=%b b_vld=%b at cycle %0d, expected 0", a_vld, b_vld, n);
      end
    end
    idle();
    model_clear();
    n_tests++;
    if (got !== 16) begin
      n_fail++;
      $display("FAIL clear_latency: got %0d cycles, expected 16", got);
    end
    for (int i = 0; i < 16; i++) begin
      a_as = 1'b0; a_rw = 1'b1; a_addr = AW'(i);
      step();
      n_tests++;
      if (a_vld !== 1'b1 || a_rd !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_read[%0d]: got vld=%b data=%h, expected vld=1 data=00000000", i, a_vld, a_rd);
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    b_as = 1'b0; b_rw = 1'b0; b_addr = 4'd5; b_be = 4'b1111; b_wd = 32'hAABBCCDD;
    step();
    b_be = 4'b0101; b_wd = 32'h11223344;
    step();
    b_as = 1'b1;
    a_as = 1'b0; a_rw = 1'b1; a_addr = 4'd5;
    step();
    n_tests++;
    if (a_vld !== 1'b1 || a_rd !== 32'hAA22CC44 || b_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_enable: got vld=%b data=%h b_vld=%b, expected vld=1 data=aa22cc44 b_vld=0", a_vld, a_rd, b_vld);
    end
    idle();
    step();
    n_tests++;
    if (a_vld !== 1'b0 || a_rd !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL read_hold: got vld=%b data=%h, expected vld=0 data=aa22cc44", a_vld, a_rd);
    end
  endtask

  task automatic test_read_first();
    a_as = 1'b0; a_rw = 1'b1; a_addr = 4'd7;
    b_as = 1'b0; b_rw = 1'b0; b_addr = 4'd7; b_be = 4'hF; b_wd = 32'hDEADBEEF;
    step();
    n_tests++;
    if (a_vld !== 1'b1 || a_rd !== 32'h0 || coll !== 1'b0) begin
      n_fail++;
      $display("FAIL read_first: got vld=%b data=%h coll=%b, expected vld=1 data=00000000 coll=0", a_vld, a_rd, coll);
    end
    b_as = 1'b1;
    step();
    n_tests++;
    if (a_vld !== 1'b1 || a_rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_after_write: got vld=%b data=%h, expected vld=1 data=deadbeef", a_vld, a_rd);
    end
    idle();
  endtask

  task automatic test_write_write();
    a_as = 1'b0; a_rw = 1'b0; a_addr = 4'd3; a_be = 4'b0011; a_wd = 32'h11111111;
    b_as = 1'b0; b_rw = 1'b0; b_addr = 4'd3; b_be = 4'b0110; b_wd = 32'h22222222;
    step();
    n_tests++;
    if (coll !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_pulse: got %b, expected 1", coll);
    end
    idle();
    a_as = 1'b0; a_rw = 1'b1; a_addr = 4'd3;
    step();
    n_tests++;
    if (coll !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_width: got %b, expected 0", coll);
    end
    n_tests++;
    if (a_rd !== 32'h00222211) begin
      n_fail++;
      $display("FAIL ww_merge: got %h, expected 00222211", a_rd);
    end
    idle();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      a_as = 1'b0; a_rw = 1'b1; a_addr = AW'(i);
      b_as = 1'b0; b_rw = 1'b0; b_addr = AW'(8 + i); b_be = 4'hF; b_wd = $urandom;
      step();
      n_tests++;
      if (a_vld !== 1'b1 || a_rd !== exp_rda) begin
        n_fail++;
        $display("FAIL stream[%0d]: got vld=%b data=%h, expected vld=1 data=%h", i, a_vld, a_rd, exp_rda);
      end
    end
    idle();
    step();
    n_tests++;
    if (a_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: got vld=%b, expected 0", a_vld);
    end
    for (int i = 8; i < 16; i++) begin
      b_as = 1'b0; b_rw = 1'b1; b_addr = AW'(i);
      step();
      n_tests++;
      if (b_vld !== 1'b1 || b_rd !== exp_rdb) begin
        n_fail++;
        $display("FAIL stream_wb[%0d]: got vld=%b data=%h, expected vld=1 data=%h", i, b_vld, b_rd, exp_rdb);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      a_as = ($urandom_range(0, 3) == 0); b_as = ($urandom_range(0, 3) == 0);
      a_rw = $urandom_range(0, 1); b_rw = $urandom_range(0, 1);
      a_addr = AW'($urandom_range(0, (n < 150) ? 3 : 15));
      b_addr = AW'($urandom_range(0, (n < 150) ? 3 : 15));
      a_be = BW'($urandom); b_be = BW'($urandom);
      a_wd = $urandom; b_wd = $urandom;
      step();
      n_tests++;
      if (a_vld !== exp_vla || a_rd !== exp_rda || b_vld !== exp_vlb || b_rd !== exp_rdb || coll !== exp_coll) begin
        n_fail++;
        $display("FAIL random[%0d]: got a=%b/%h b=%b/%h coll=%b, expected a=%b/%h b=%b/%h coll=%b",
                 n, a_vld, a_rd, b_vld, b_rd, coll, exp_vla, exp_rda, exp_vlb, exp_rdb, exp_coll);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int got;
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    for (int n = 0; n < 9; n++) tick();
    n_tests++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_rdy: got %b, expected 0", rdy);
    end
    reset_ = 1'b0;
    tick();
    n_tests++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_reset_rdy: got %b, expected 0", rdy);
    end
    reset_ = 1'b1;
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rdy) begin got = n; break; end
    end
    model_clear();
    n_tests++;
    if (got !== 16) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d cycles, expected 16", got);
    end
    for (int i = 0; i < 16; i++) begin
      a_as = 1'b0; a_rw = 1'b1; a_addr = AW'(i);
      step();
      n_tests++;
      if (a_rd !== exp_rda || a_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL restart_read[%0d]: got vld=%b data=%h, expected vld=1 data=%h", i, a_vld, a_rd, exp_rda);
      end
    end
    idle();
  endtask

  initial begin
    model_clear();
    reset_ = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    for (int n = 0; n < 40 && !rdy; n++) tick();
    test_reset();
    test_byte_enable();
    test_read_first();
    test_write_write();
    test_streaming();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
